// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock ratio detector.
// Optional input synchronizer is selected with CLK_DIV_DETECT_SYNC_EN.
package clk_div_pkg;

  localparam int unsigned DEF_W          = 8;
  localparam int unsigned DEF_LOCK_COUNT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/clk_in_edge_detect.sv
// Conditions the divided clock: optional 2-flop synchronizer (CLK_DIV_DETECT_SYNC_EN),
// then a previous-sample register producing a single-cycle rise strobe.
module clk_in_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  output logic clk_in_s_c,
  output logic rise_c
);

  logic prev_q;

`ifdef CLK_DIV_DETECT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], clk_in};
    end
  end

  assign clk_in_s_c = sync_q[1];
`else
  // Divided clock is already synchronous to clk; sample it directly.
  assign clk_in_s_c = clk_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= clk_in_s_c;
    end
  end

  assign rise_c = clk_in_s_c & ~prev_q;

endmodule

// File: rtl/clk_div_ratio_detector.sv
// Recovers the divide ratio and high time of a divided clock, flags lock and stuck input.
// Build option: CLK_DIV_DETECT_SYNC_EN inserts a 2-flop synchronizer ahead of edge detect.
module clk_div_ratio_detector
  import clk_div_pkg::*;
#(
  parameter int unsigned W          = DEF_W,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clkIn,
  output logic [W-1:0] ratio,
  output logic [W-1:0] highCnt,
  output logic         ratioValid,
  output logic         locked,
  output logic         stuckErr
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  // Longest period still measurable; one more cycle without a rise is a timeout.
  localparam logic [W-1:0]  PER_LIMIT = W'((1 << W) - 2);
  localparam logic [MW-1:0] MATCH_SAT = MW'(LOCK_COUNT);

  state_t        state;
  state_t        state_next;
  logic          clk_in_s_c;
  logic          rise_c;
  logic [W-1:0]  per_cnt;
  logic [W-1:0]  hi_cnt;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_next_c;
  logic          at_limit_c;
  logic          clear_c;
  logic          start_c;
  logic          capture_c;
  logic          timeout_c;
  logic          count_c;

  clk_in_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clkIn),
    .clk_in_s_c (clk_in_s_c),
    .rise_c     (rise_c)
  );

  assign at_limit_c = (per_cnt == PER_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = ALIGN;
      end
      ALIGN: begin
        if (!enable)     state_next = IDLE;
        else if (rise_c) state_next = MEASURE;
      end
      MEASURE: begin
        if (!enable)                    state_next = IDLE;
        else if (!rise_c && at_limit_c) state_next = ALIGN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode the datapath action for this cycle; enable low overrides any edge.
  always_comb begin
    clear_c   = 1'b0;
    start_c   = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    count_c   = 1'b0;
    case (state)
      IDLE: begin
        clear_c = 1'b1;
      end
      ALIGN: begin
        if (!enable)     clear_c = 1'b1;
        else if (rise_c) start_c = 1'b1;
      end
      MEASURE: begin
        if (!enable)          clear_c   = 1'b1;
        else if (rise_c)      capture_c = 1'b1;
        else if (at_limit_c)  timeout_c = 1'b1;
        else                  count_c   = 1'b1;
      end
      default: clear_c = 1'b1;
    endcase
  end

  always_comb begin
    match_next_c = MW'(1);
    if ((match_cnt != '0) && (per_cnt == ratio)) begin
      if (match_cnt < MATCH_SAT) match_next_c = match_cnt + MW'(1);
      else                       match_next_c = match_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      match_cnt  <= '0;
      ratio      <= '0;
      highCnt    <= '0;
      ratioValid <= 1'b0;
      locked     <= 1'b0;
      stuckErr   <= 1'b0;
    end else begin
      ratioValid <= 1'b0;
      stuckErr   <= 1'b0;
      if (clear_c) begin
        per_cnt   <= '0;
        hi_cnt    <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else if (start_c) begin
        per_cnt <= W'(1);
        hi_cnt  <= W'(clk_in_s_c);
      end else if (capture_c) begin
        ratio      <= per_cnt;
        highCnt    <= hi_cnt;
        ratioValid <= 1'b1;
        match_cnt  <= match_next_c;
        locked     <= (match_next_c >= MATCH_SAT);
        per_cnt    <= W'(1);
        hi_cnt     <= W'(clk_in_s_c);
      end else if (timeout_c) begin
        stuckErr  <= 1'b1;
        ratio     <= '0;
        highCnt   <= '0;
        locked    <= 1'b0;
        match_cnt <= '0;
        per_cnt   <= '0;
        hi_cnt    <= '0;
      end else if (count_c) begin
        per_cnt <= per_cnt + W'(1);
        hi_cnt  <= hi_cnt + W'(clk_in_s_c);
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ratio_detector.sv
// Randomized scoreboard bench for clk_div_ratio_detector; honours CLK_DIV_DETECT_SYNC_EN.
module tb_clk_div_ratio_detector;

  localparam int unsigned W = 8;
  localparam int unsigned L = 3;
`ifdef CLK_DIV_DETECT_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         clk_in;
  logic [W-1:0] ratio;
  logic [W-1:0] high_cnt;
  logic         ratio_valid;
  logic         locked;
  logic         stuck_err;

  always #5 clk = ~clk;

  clk_div_ratio_detector #(.W(W), .LOCK_COUNT(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clkIn      (clk_in),
    .ratio      (ratio),
    .highCnt    (high_cnt),
    .ratioValid (ratio_valid),
    .locked     (locked),
    .stuckErr   (stuck_err)
  );

  typedef struct {
    bit          stuck;
    int          cyc;
    int unsigned ratio;
    int unsigned high;
    bit          locked;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  n_cmp  = 0;
  int  n_fail = 0;

  // Reference model: works on the window of samples seen since the last rising edge.
  int          m_mode = 0;   // 0 disabled, 1 waiting for first edge, 2 measuring
  bit          m_d1, m_d2, m_prev;
  bit          win[$];
  int unsigned m_ratio = 0;
  int unsigned m_high = 0;
  int unsigned m_match = 0;
  bit          m_locked = 1'b0;

  always @(posedge clk) begin
    bit s;
    bit rise;
    int unsigned n;
    int unsigned h;
    ev_t e;
    cyc++;
    if (rst) begin
      m_mode = 0; m_d1 = 0; m_d2 = 0; m_prev = 0; win.delete();
      m_ratio = 0; m_high = 0; m_match = 0; m_locked = 0;
    end else begin
      s = SYNC ? m_d2 : clk_in;
      rise = s && !m_prev;
      m_d2 = m_d1; m_d1 = clk_in; m_prev = s;
      if (!enable) begin
        m_mode = 0; m_match = 0; m_locked = 0; win.delete();
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (rise) begin
          m_mode = 2; win.delete(); win.push_back(s);
        end
      end else if (rise) begin
        n = win.size();
        h = 0;
        foreach (win[i]) h += 32'(win[i]);
        if (m_match != 0 && n == m_ratio) m_match = (m_match < L) ? m_match + 1 : L;
        else m_match = 1;
        m_ratio = n; m_high = h; m_locked = (m_match >= L);
        e = '{1'b0, cyc, n, h, m_locked};
        exp_q.push_back(e);
        win.delete(); win.push_back(s);
      end else if (win.size() == (1 << W) - 2) begin
        m_ratio = 0; m_high = 0; m_match = 0; m_locked = 0; m_mode = 1;
        e = '{1'b1, cyc, 0, 0, 1'b0};
        exp_q.push_back(e);
        win.delete();
      end else begin
        win.push_back(s);
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: level outputs every cycle, pulses against the scoreboard queue.
  always @(negedge clk) begin
    ev_t e;
    if (cyc >= 1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check(e.stuck ? "missing_stuckErr" : "missing_ratioValid", 0, 1);
      end
      check("ratio", 32'(ratio), m_ratio);
      check("highCnt", 32'(high_cnt), m_high);
      check("locked", 32'(locked), 32'(m_locked));
      if (ratio_valid || stuck_err) begin
        if (exp_q.size() == 0) begin
          check(ratio_valid ? "unexpected_ratioValid" : "unexpected_stuckErr", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          check("ratioValid", 32'(ratio_valid), 32'(!e.stuck));
          check("stuckErr", 32'(stuck_err), 32'(e.stuck));
          if (!e.stuck) begin
            check("pulse_ratio", 32'(ratio), e.ratio);
            check("pulse_high", 32'(high_cnt), e.high);
            check("pulse_locked", 32'(locked), 32'(e.locked));
          end
        end
      end
    end
  end

  task automatic tick(input bit x);
    @(negedge clk);
    clk_in = x;
  endtask

  task automatic div(input int n, input int h, input int p);
    for (int k = 0; k < p; k++)
      for (int i = 0; i < n; i++) tick(i < h);
  endtask

  task automatic hold(input bit x, input int k);
    for (int i = 0; i < k; i++) tick(x);
  endtask

  initial begin
    int n;
    int h;
    rst = 1'b1; enable = 1'b0; clk_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(0, 4);
    enable = 1'b1;
    div(9, 4, 6);
    div(5, 2, 5);
    hold(0, 300);
    div(9, 4, 5);
    div(2, 1, 8);
    div(7, 3, 2);
    hold(1, 2);
    enable = 1'b0;
    hold(0, 10);
    enable = 1'b1;
    div(7, 3, 5);
    @(negedge clk); rst = 1'b1; clk_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    div(6, 3, 5);
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(40, 2);
      h = $urandom_range(n - 1, 1);
      div(n, h, $urandom_range(6, 1));
      if ($urandom_range(4, 0) == 0) hold(0, $urandom_range(10, 0));
      if ($urandom_range(5, 0) == 0) begin
        @(negedge clk); enable = 1'b0; clk_in = 1'($urandom_range(1, 0));
        for (int j = 0; j < int'($urandom_range(8, 1)); j++) tick(1'($urandom_range(1, 0)));
        enable = 1'b1;
      end
    end
    div(254, 100, 4);
    div(255, 100, 3);
    hold(0, 300);
    hold(0, 10);
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      check("pending_pulse", 0, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
